// File: rtl/elastic_fifo.sv
// elastic_fifo: valid/ready circular-buffer FIFO of DEPTH entries.
// Optional ELASTIC_FIFO_BYPASS_EN: zero-latency pass-through when empty.
module elastic_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("elastic_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             has_data;
    logic             push;
    logic             pop;

    // handshake decode; in_ready looks only at registered state
    always_comb begin
        has_data  = (count != '0);
        in_ready  = (count != FULL);
        pop       = has_data & out_ready;
`ifdef ELASTIC_FIFO_BYPASS_EN
        out_valid = has_data | in_valid;
        push      = in_valid & in_ready & ~(~has_data & out_ready);
        if (has_data)
            out_data = mem[rd_ptr];
        else if (in_valid)
            out_data = in_data;
        else
            out_data = '0;
`else
        out_valid = has_data;
        push      = in_valid & in_ready;
        out_data  = has_data ? mem[rd_ptr] : '0;
`endif
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= in_data;
    end

`ifndef SYNTHESIS
    a_hold: assert property (@(posedge clk) disable iff (reset)
        (in_valid && !in_ready) |=> $stable(in_data));

    a_cnt: assert property (@(posedge clk) disable iff (reset)
        count <= FULL);
`endif

endmodule

// File: tb/tb_elastic_fifo.sv
// tb_elastic_fifo: vector table plus queue scoreboard for elastic_fifo.
// Builds in either ELASTIC_FIFO_BYPASS_EN mode.
module tb_elastic_fifo;

    localparam int D = 4;
`ifdef ELASTIC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [$];

    typedef struct {
        logic       r;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        bit         chk;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [20];

    always #5 clk = ~clk;

    elastic_fifo #(.WIDTH(8), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    task automatic cmp(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic iv,
                                input logic [7:0] d, input logic ordy);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.ordy = ordy;
        v.chk = 1'b0; v.ov = 1'b0; v.od = 8'h00; v.ir = 1'b0; v.cnt = 3'd0;
        return v;
    endfunction

    function automatic vec_t ex(input logic iv, input logic [7:0] d,
                                input logic ordy, input logic ov,
                                input logic [7:0] od, input logic ir,
                                input logic [2:0] cnt);
        vec_t v;
        v.r = 1'b0; v.iv = iv; v.d = d; v.ordy = ordy;
        v.chk = 1'b1; v.ov = ov; v.od = od; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    // drive one cycle, check at the negedge, update the scoreboard after the edge
    task automatic step(input vec_t v, input string tag);
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ir;
        logic [2:0] e_cnt;
        bit         acc;
        reset     = v.r;
        in_valid  = v.iv;
        in_data   = v.d;
        out_ready = v.ordy;
        @(negedge clk);
        if (!v.r) begin
            e_cnt = 3'(sb.size());
            e_ir  = (sb.size() != D);
            e_ov  = (sb.size() != 0) || (BYP && v.iv);
            e_od  = (sb.size() != 0) ? sb[0]
                  : ((BYP && v.iv) ? v.d : 8'h00);
            cmp({tag, " sb count"}, 32'(count), 32'(e_cnt));
            cmp({tag, " sb in_ready"}, 32'(in_ready), 32'(e_ir));
            cmp({tag, " sb out_valid"}, 32'(out_valid), 32'(e_ov));
            cmp({tag, " sb out_data"}, 32'(out_data), 32'(e_od));
            if (v.chk) begin
                e_ov = v.ov;
                e_od = v.od;
                if (BYP && v.cnt == 3'd0 && v.iv) begin
                    e_ov = 1'b1;
                    e_od = v.d;
                end
                cmp({tag, " count"}, 32'(count), 32'(v.cnt));
                cmp({tag, " in_ready"}, 32'(in_ready), 32'(v.ir));
                cmp({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
                cmp({tag, " out_data"}, 32'(out_data), 32'(e_od));
            end
        end
        @(posedge clk);
        #1;
        if (v.r) begin
            sb.delete();
        end else begin
            acc = v.iv && (sb.size() != D)
                  && !(BYP && sb.size() == 0 && v.ordy);
            if (v.ordy && sb.size() != 0)
                void'(sb.pop_front());
            if (acc)
                sb.push_back(v.d);
        end
    endtask

    initial begin
        // fill three, then drain
        tbl[0]  = ex(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);
        tbl[1]  = ex(1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 3'd1);
        tbl[2]  = ex(1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b1, 3'd2);
        tbl[3]  = ex(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 3'd3);
        tbl[4]  = ex(1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 3'd3);
        tbl[5]  = ex(1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 3'd2);
        tbl[6]  = ex(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 3'd1);
        tbl[7]  = ex(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);
        // fill to full, pop while full does not open in_ready
        tbl[8]  = ex(1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);
        tbl[9]  = ex(1'b1, 8'hA1, 1'b0, 1'b1, 8'hA0, 1'b1, 3'd1);
        tbl[10] = ex(1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 1'b1, 3'd2);
        tbl[11] = ex(1'b1, 8'hA3, 1'b0, 1'b1, 8'hA0, 1'b1, 3'd3);
        tbl[12] = ex(1'b1, 8'hA4, 1'b1, 1'b1, 8'hA0, 1'b0, 3'd4);
        tbl[13] = ex(1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 1'b1, 3'd3);
        tbl[14] = ex(1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 3'd4);
        tbl[15] = ex(1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b0, 3'd4);
        tbl[16] = ex(1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b1, 3'd3);
        tbl[17] = ex(1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b1, 3'd2);
        tbl[18] = ex(1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 3'd1);
        tbl[19] = ex(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        step(mk(1'b1, 1'b0, 8'h00, 1'b0), "rst");

        for (int i = 0; i < 20; i++)
            step(tbl[i], $sformatf("row%0d", i));

        // steady push+pop at depth 2 across pointer wrap
        step(mk(1'b0, 1'b1, 8'hF0, 1'b0), "t3 pre0");
        step(mk(1'b0, 1'b1, 8'hF1, 1'b0), "t3 pre1");
        for (int i = 0; i < 10; i++)
            step(mk(1'b0, 1'b1, 8'(i), 1'b1), $sformatf("t3 c%0d", i));
        step(ex(1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 3'd2), "t3 tail0");
        step(ex(1'b0, 8'h00, 1'b1, 1'b1, 8'h09, 1'b1, 3'd1), "t3 tail1");
        step(ex(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0), "t3 end");

        // reset mid-stream with a push offered
        step(mk(1'b0, 1'b1, 8'hC1, 1'b0), "t4 f1");
        step(mk(1'b0, 1'b1, 8'hC2, 1'b0), "t4 f2");
        step(mk(1'b0, 1'b1, 8'hC3, 1'b0), "t4 f3");
        step(mk(1'b1, 1'b1, 8'hC4, 1'b0), "t4 rst");
        step(ex(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0), "t4 post");
        step(ex(1'b1, 8'hD1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0), "t4 push");
        step(ex(1'b0, 8'h00, 1'b1, 1'b1, 8'hD1, 1'b1, 3'd1), "t4 pop");
        step(ex(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0), "t4 end");

        // empty-FIFO offer with and without a ready consumer
        step(ex(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0), "t5 offer");
`ifdef ELASTIC_FIFO_BYPASS_EN
        step(ex(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0), "t5 after");
`else
        step(ex(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 3'd1), "t6 held");
        step(ex(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b1, 3'd1), "t6 pop");
`endif
        step(ex(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0), "t5 stall");
        step(ex(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 3'd1), "t5 held");
        step(ex(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b1, 3'd1), "t5 pop");
        step(ex(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0), "t5 end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
